// File: rtl/uart_cfg_shadow_tx.sv
// rtl/uart_cfg_shadow_tx.sv - configuration shadow register with an 8N1 UART uppercase-hex dumper
// Optional CR/LF terminator after the hex digits: define CFG_SHOW_CRLF_EN.
module uart_cfg_shadow_tx #(
    parameter int BUS_WIDTH = 32,
    parameter int CLK_DIV   = 87
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] busDefault,
    input  logic                 loadDefault,
    input  logic                 setEn,
    input  logic [BUS_WIDTH-1:0] setData,
    output logic [BUS_WIDTH-1:0] busNow,
    input  logic                 showReq,
    output logic                 busy,
    output logic                 showDone,
    output logic                 uTx
);

    localparam int N = BUS_WIDTH / 4;
`ifdef CFG_SHOW_CRLF_EN
    localparam int NCHAR = N + 2;
`else
    localparam int NCHAR = N;
`endif
    localparam int CHW = $clog2(NCHAR + 1);
    localparam int CNW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNW-1:0] CNT_LAST  = CNW'(CLK_DIV - 1);
    localparam logic [CHW-1:0] CHAR_LAST = CHW'(NCHAR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] busNow_q, busNow_d;
    logic [BUS_WIDTH-1:0] snap_q, snap_d;
    logic [7:0]           byte_q, byte_d;
    logic [CNW-1:0]       cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [CHW-1:0]       char_q, char_d;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        state_d  = state_q;
        busNow_d = busNow_q;
        snap_d   = snap_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        char_d   = char_q;

        if (loadDefault) begin
            busNow_d = busDefault;
        end else if (setEn) begin
            busNow_d = setData;
        end

        case (state_q)
            S_IDLE: begin
                // LOAD takes no line time: the first character is set up on the accepting edge
                if (showReq) begin
                    state_d = S_START;
                    snap_d  = busNow_q << 4;
                    byte_d  = hex_char(busNow_q[BUS_WIDTH-1 -: 4]);
                    cnt_d   = '0;
                    bit_d   = '0;
                    char_d  = '0;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CNW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q + CNW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = cnt_q + CNW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (char_q == CHAR_LAST) begin
                        state_d = S_DONE;
                        char_d  = '0;
                    end else begin
                        state_d = S_START;
                        char_d  = char_q + CHW'(1);
                        snap_d  = snap_q << 4;
                        byte_d  = hex_char(snap_q[BUS_WIDTH-1 -: 4]);
`ifdef CFG_SHOW_CRLF_EN
                        if (char_q == CHW'(N - 1)) begin
                            byte_d = 8'h0D;
                        end else if (char_q == CHW'(N)) begin
                            byte_d = 8'h0A;
                        end
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                char_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busNow_q <= busDefault;
            snap_q   <= '0;
            byte_q   <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            char_q   <= '0;
        end else begin
            state_q  <= state_d;
            busNow_q <= busNow_d;
            snap_q   <= snap_d;
            byte_q   <= byte_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            char_q   <= char_d;
        end
    end

    assign busNow   = busNow_q;
    assign busy     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign showDone = (state_q == S_DONE);
    assign uTx      = (state_q == S_START) ? 1'b0 :
                      (state_q == S_DATA)  ? byte_q[bit_q] : 1'b1;

endmodule
